// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory arbiter: default memory geometry,
// the requester owner tag and the command record carried into the memory
// command stage.
// Configuration macro: DMEM_ARB_LOCK_EN (used by rr_arbiter2 / dmem_arbiter).
// -----------------------------------------------------------------------------
package dmem_pkg;

    // Geometry of the 64-bit x 1024-entry data memory.
    localparam int DMEM_DATA_W = 64;
    localparam int DMEM_ADDR_W = 10;

    // Which requester owns an in-flight command.
    typedef logic owner_t;
    localparam owner_t OWN_REQ0 = 1'b0;
    localparam owner_t OWN_REQ1 = 1'b1;

    // One memory access as selected by the arbiter in the grant cycle.
    typedef struct packed {
        logic                   rd;
        logic                   wr;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] data;
        owner_t                 owner;
    } cmd_t;

endpackage

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin arbiter. Grants are combinational from the requests and
// the registered pointer; the pointer always moves to favour the requester
// that was not just granted.
// With DMEM_ARB_LOCK_EN defined, a granted requester asserting its lock input
// becomes lock owner and keeps the bus while it holds req+lock, for at most
// LOCK_MAX consecutive grants.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   req0, req1      access requests
//   lock0, lock1    bus lock requests (DMEM_ARB_LOCK_EN only)
//   gnt0, gnt1      one-hot grant, forced low while reset is asserted
// -----------------------------------------------------------------------------
module rr_arbiter2
    import dmem_pkg::*;
#(
    parameter int LOCK_MAX = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
`ifdef DMEM_ARB_LOCK_EN
    input  logic lock0,
    input  logic lock1,
`endif
    output logic gnt0,
    output logic gnt1
);

    // ptr = 0 favours requester 0, ptr = 1 favours requester 1.
    logic ptr_q, ptr_d;
    logic gnt0_c, gnt1_c;

`ifdef DMEM_ARB_LOCK_EN
    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

    logic             own_vld_q, own_vld_d;
    owner_t           own_q, own_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_next;
    logic             lock_hold;
    logic             granted_lock;
`endif

    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt0_c = req0 && (!req1 || !ptr_q);
        gnt1_c = req1 && (!req0 || ptr_q);

`ifdef DMEM_ARB_LOCK_EN
        // The owner keeps the bus only while it still asks for it and locks.
        lock_hold = own_vld_q &&
                    ((own_q == OWN_REQ0) ? (req0 && lock0) : (req1 && lock1));
        if (lock_hold) begin
            gnt0_c = (own_q == OWN_REQ0);
            gnt1_c = (own_q == OWN_REQ1);
        end
`endif

        // No grants while reset is held, so nothing enters the pipeline.
        gnt0_c = gnt0_c && rst_n;
        gnt1_c = gnt1_c && rst_n;

        ptr_d = ptr_q;
        if (gnt0_c) begin
            ptr_d = 1'b1;
        end else if (gnt1_c) begin
            ptr_d = 1'b0;
        end

`ifdef DMEM_ARB_LOCK_EN
        own_vld_d    = own_vld_q;
        own_d        = own_q;
        cnt_d        = cnt_q;
        cnt_next     = lock_hold ? (cnt_q + 1'b1) : {{(CNT_W-1){1'b0}}, 1'b1};
        granted_lock = (gnt0_c && lock0) || (gnt1_c && lock1);

        if (!lock_hold) begin
            own_vld_d = 1'b0;
            cnt_d     = '0;
        end

        if (granted_lock) begin
            if (cnt_next >= CNT_MAX) begin
                // Forced release; the pointer already favours the other side.
                own_vld_d = 1'b0;
                cnt_d     = '0;
            end else begin
                own_vld_d = 1'b1;
                own_d     = gnt1_c ? OWN_REQ1 : OWN_REQ0;
                cnt_d     = cnt_next;
            end
        end
`endif
    end

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q     <= 1'b0;
`ifdef DMEM_ARB_LOCK_EN
            own_vld_q <= 1'b0;
            own_q     <= OWN_REQ0;
            cnt_q     <= '0;
`endif
        end else begin
            ptr_q     <= ptr_d;
`ifdef DMEM_ARB_LOCK_EN
            own_vld_q <= own_vld_d;
            own_q     <= own_d;
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign gnt0 = gnt0_c;
    assign gnt1 = gnt1_c;

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Arbiter and sequencer in front of the 64-bit x 1024-entry data memory.
// Cycle N: combinational grant. N+1: registered read or write command to the
// memory. N+2: read data registered back to the owning requester with a
// one-cycle rvalid pulse. Writes produce no response.
// Configuration macro: DMEM_ARB_LOCK_EN adds lock0/lock1; LOCK_MAX is only
// used when it is defined.
// DATA_W/ADDR_W must stay equal to the dmem_pkg geometry used by cmd_t.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   req/we/addr/wdata 0,1           requester inputs, held until granted
//   gnt0, gnt1                      request accepted this cycle
//   rvalid0/rdata0, rvalid1/rdata1  read responses
//   mem_data_in, mem_read_adr,
//   mem_write_adr, mem_rd, mem_wr   registered memory command
//   mem_data_out                    memory read data, valid while mem_rd
//   lock0, lock1                    bus lock (DMEM_ARB_LOCK_EN only)
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DATA_W   = DMEM_DATA_W,
    parameter int ADDR_W   = DMEM_ADDR_W,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,

    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,

`ifdef DMEM_ARB_LOCK_EN
    input  logic              lock0,
    input  logic              lock1,
`endif

    output logic [DATA_W-1:0] mem_data_in,
    output logic [ADDR_W-1:0] mem_read_adr,
    output logic [ADDR_W-1:0] mem_write_adr,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_data_out
);

    // ---------------------------------------------------------------- grant
    rr_arbiter2 #(
        .LOCK_MAX (LOCK_MAX)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req0  (req0),
        .req1  (req1),
`ifdef DMEM_ARB_LOCK_EN
        .lock0 (lock0),
        .lock1 (lock1),
`endif
        .gnt0  (gnt0),
        .gnt1  (gnt1)
    );

    // ------------------------------------------------------ command stage
    cmd_t cmd_new;

    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    owner_t            owner_q, owner_d;
    logic [ADDR_W-1:0] rd_adr_q, rd_adr_d;
    logic [ADDR_W-1:0] wr_adr_q, wr_adr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    // ----------------------------------------------------- response stage
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    always_comb begin
        // Select the granted requester's access; grants are one-hot.
        cmd_new.rd    = (gnt0 && !we0) || (gnt1 && !we1);
        cmd_new.wr    = (gnt0 &&  we0) || (gnt1 &&  we1);
        cmd_new.addr  = gnt1 ? addr1  : addr0;
        cmd_new.data  = gnt1 ? wdata1 : wdata0;
        cmd_new.owner = gnt1 ? OWN_REQ1 : OWN_REQ0;

        rd_d    = cmd_new.rd;
        wr_d    = cmd_new.wr;
        owner_d = cmd_new.owner;

        // Address/data registers only move when their strobe fires.
        rd_adr_d = cmd_new.rd ? cmd_new.addr : rd_adr_q;
        wr_adr_d = cmd_new.wr ? cmd_new.addr : wr_adr_q;
        wdata_d  = cmd_new.wr ? cmd_new.data : wdata_q;

        // Memory data is valid in the command cycle; capture it for the owner.
        rvalid0_d = rd_q && (owner_q == OWN_REQ0);
        rvalid1_d = rd_q && (owner_q == OWN_REQ1);
        rdata0_d  = rvalid0_d ? mem_data_out : rdata0_q;
        rdata1_d  = rvalid1_d ? mem_data_out : rdata1_q;
    end

    // Reset drops any in-flight command and response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            owner_q   <= OWN_REQ0;
            rd_adr_q  <= '0;
            wr_adr_q  <= '0;
            wdata_q   <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            owner_q   <= owner_d;
            rd_adr_q  <= rd_adr_d;
            wr_adr_q  <= wr_adr_d;
            wdata_q   <= wdata_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign mem_rd        = rd_q;
    assign mem_wr        = wr_q;
    assign mem_read_adr  = rd_adr_q;
    assign mem_write_adr = wr_adr_q;
    assign mem_data_in   = wdata_q;
    assign rvalid0       = rvalid0_q;
    assign rvalid1       = rvalid1_q;
    assign rdata0        = rdata0_q;
    assign rdata1        = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with a behavioural 64 x 1024 memory:
// combinational read of mem_read_adr, write on the clock edge while mem_wr.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit
// later, well away from the edge. Define DMEM_ARB_LOCK_EN to add the lock case.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0, we0, gnt0, rvalid0;
    logic [9:0]  addr0;
    logic [63:0] wdata0, rdata0;
    logic        req1, we1, gnt1, rvalid1;
    logic [9:0]  addr1;
    logic [63:0] wdata1, rdata1;
    logic [63:0] mem_data_in, mem_data_out;
    logic [9:0]  mem_read_adr, mem_write_adr;
    logic        mem_rd, mem_wr;
`ifdef DMEM_ARB_LOCK_EN
    logic        lock0, lock1;
`endif

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(
        .LOCK_MAX (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req0          (req0),
        .we0           (we0),
        .addr0         (addr0),
        .wdata0        (wdata0),
        .gnt0          (gnt0),
        .rvalid0       (rvalid0),
        .rdata0        (rdata0),
        .req1          (req1),
        .we1           (we1),
        .addr1         (addr1),
        .wdata1        (wdata1),
        .gnt1          (gnt1),
        .rvalid1       (rvalid1),
        .rdata1        (rdata1),
`ifdef DMEM_ARB_LOCK_EN
        .lock0         (lock0),
        .lock1         (lock1),
`endif
        .mem_data_in   (mem_data_in),
        .mem_read_adr  (mem_read_adr),
        .mem_write_adr (mem_write_adr),
        .mem_rd        (mem_rd),
        .mem_wr        (mem_wr),
        .mem_data_out  (mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ----------------------------------------------------- memory model
    logic [63:0] mem [0:1023];

    function automatic logic [63:0] init_val(input int i);
        return 64'hC0DE_0000_0000_0000 | 64'(i);
    endfunction

    assign mem_data_out = mem[mem_read_adr];

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (mem_wr) mem[mem_write_adr] <= mem_data_in;
        end
    end

    // ---------------------------------------------------------- helpers
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic r, input logic w, input logic [9:0] a, input logic [63:0] d);
        req0 = r; we0 = w; addr0 = a; wdata0 = d;
    endtask

    task automatic set1(input logic r, input logic w, input logic [9:0] a, input logic [63:0] d);
        req1 = r; we1 = w; addr1 = a; wdata1 = d;
    endtask

    // --------------------------------------------------------- stimulus
    initial begin
        logic exp0, exp1;
        int   j;

        rst_n = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
        lock0 = 1'b0;
        lock1 = 1'b0;
`endif
        set0(1'b1, 1'b0, 10'd5, 64'd0);
        set1(1'b1, 1'b0, 10'd6, 64'd0);

        // Reset held for two edges with both requesting.
        tick();
        tick();
        #1;
        check("rst_gnt0",    gnt0,         1'b0);
        check("rst_gnt1",    gnt1,         1'b0);
        check("rst_mem_rd",  mem_rd,       1'b0);
        check("rst_mem_wr",  mem_wr,       1'b0);
        check("rst_rvalid0", rvalid0,      1'b0);
        check("rst_rvalid1", rvalid1,      1'b0);
        check("rst_rdata0",  rdata0,       64'd0);
        check("rst_rdata1",  rdata1,       64'd0);
        check("rst_radr",    mem_read_adr, 10'd0);
        check("rst_wadr",    mem_write_adr,10'd0);
        check("rst_din",     mem_data_in,  64'd0);
        tick();

        // First grant after release favours requester 0.
        rst_n = 1'b1;
        #1;
        check("first_gnt0", gnt0, 1'b1);
        check("first_gnt1", gnt1, 1'b0);
        tick();
        set0(1'b0, 1'b0, 10'd0, 64'd0);
        set1(1'b0, 1'b0, 10'd0, 64'd0);
        #1;
        check("first_mem_rd", mem_rd,       1'b1);
        check("first_radr",   mem_read_adr, 10'd5);
        check("first_mem_wr", mem_wr,       1'b0);
        tick();
        #1;
        check("first_rvalid0", rvalid0, 1'b1);
        check("first_rdata0",  rdata0,  init_val(5));
        check("first_rvalid1", rvalid1, 1'b0);
        tick();
        #1;
        check("first_rvalid0_pulse", rvalid0, 1'b0);
        tick();

        // Requester 0 write then read of the same address.
        set0(1'b1, 1'b1, 10'b0110000100, 64'h0502_0000_80E0_0000);
        #1;
        check("wr_gnt0", gnt0, 1'b1);
        tick();
        set0(1'b1, 1'b0, 10'b0110000100, 64'd0);
        #1;
        check("rd_gnt0",    gnt0,          1'b1);
        check("wr_mem_wr",  mem_wr,        1'b1);
        check("wr_mem_rd",  mem_rd,        1'b0);
        check("wr_wadr",    mem_write_adr, 10'b0110000100);
        check("wr_din",     mem_data_in,   64'h0502_0000_80E0_0000);
        tick();
        set0(1'b0, 1'b0, 10'd0, 64'd0);
        #1;
        check("rd_mem_rd",   mem_rd,       1'b1);
        check("rd_mem_wr",   mem_wr,       1'b0);
        check("rd_radr",     mem_read_adr, 10'b0110000100);
        check("rd_rvalid0_early", rvalid0, 1'b0);
        tick();
        #1;
        check("rd_rvalid0", rvalid0, 1'b1);
        check("rd_rdata0",  rdata0,  64'h0502_0000_80E0_0000);
        tick();

        // Cross hazard: req1 writes, req0 reads the same word next cycle.
        set1(1'b1, 1'b1, 10'h1A4, 64'hDEAD_BEEF_0000_0001);
        #1;
        check("xh_gnt1", gnt1, 1'b1);
        check("xh_gnt0", gnt0, 1'b0);
        tick();
        set1(1'b0, 1'b0, 10'd0, 64'd0);
        set0(1'b1, 1'b0, 10'h1A4, 64'd0);
        #1;
        check("xh_rd_gnt0", gnt0,          1'b1);
        check("xh_mem_wr",  mem_wr,        1'b1);
        check("xh_wadr",    mem_write_adr, 10'h1A4);
        tick();
        set0(1'b0, 1'b0, 10'd0, 64'd0);
        #1;
        check("xh_mem_rd", mem_rd,       1'b1);
        check("xh_radr",   mem_read_adr, 10'h1A4);
        tick();
        #1;
        check("xh_rvalid0", rvalid0, 1'b1);
        check("xh_rdata0",  rdata0,  64'hDEAD_BEEF_0000_0001);
        check("xh_rvalid1", rvalid1, 1'b0);
        tick();

        // Reset one cycle after a read grant to requester 1.
        set1(1'b1, 1'b0, 10'd7, 64'd0);
        #1;
        check("mr_gnt1_a", gnt1, 1'b1);
        tick();
        set1(1'b1, 1'b0, 10'd9, 64'd0);
        #1;
        check("mr_gnt1_b", gnt1, 1'b1);
        tick();
        set1(1'b0, 1'b0, 10'd0, 64'd0);
        rst_n = 1'b0;
        #1;
        check("mr_rvalid1_a", rvalid1, 1'b1);
        check("mr_rdata1_a",  rdata1,  init_val(7));
        tick();
        rst_n = 1'b1;
        #1;
        check("mr_rvalid1_drop", rvalid1, 1'b0);
        check("mr_rdata1_zero",  rdata1,  64'd0);
        check("mr_mem_rd",       mem_rd,  1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            #1;
            check("mr_no_rvalid1", rvalid1, 1'b0);
            tick();
        end

        // Contention: both read continuously; grants alternate from 0.
        for (int k = 0; k < 8; k++) begin
            if (k < 6) begin
                set0(1'b1, 1'b0, 10'h020, 64'd0);
                set1(1'b1, 1'b0, 10'h3FF, 64'd0);
            end else begin
                set0(1'b0, 1'b0, 10'd0, 64'd0);
                set1(1'b0, 1'b0, 10'd0, 64'd0);
            end
            #1;
            if (k < 6) begin
                check("ct_gnt0", gnt0, (k % 2) == 0);
                check("ct_gnt1", gnt1, (k % 2) == 1);
            end
            if (k == 2) check("ct_radr_1023", mem_read_adr, 10'h3FF);
            if (k >= 2) begin
                j    = k - 2;
                exp0 = (j < 6) && ((j % 2) == 0);
                exp1 = (j < 6) && ((j % 2) == 1);
                check("ct_rvalid0", rvalid0, exp0);
                check("ct_rvalid1", rvalid1, exp1);
                if (exp0) check("ct_rdata0", rdata0, init_val(10'h020));
                if (exp1) check("ct_rdata1", rdata1, init_val(10'h3FF));
            end
            tick();
        end

`ifdef DMEM_ARB_LOCK_EN
        // Lock: 4 locked grants to 0, forced release to 1, then 0 re-locks.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            set0(1'b1, 1'b0, 10'd3, 64'd0);
            set1(1'b1, 1'b0, 10'd4, 64'd0);
            lock0 = 1'b1;
            lock1 = 1'b0;
            #1;
            check("lk_gnt0", gnt0, k != 4);
            check("lk_gnt1", gnt1, k == 4);
            tick();
        end
        set0(1'b0, 1'b0, 10'd0, 64'd0);
        set1(1'b0, 1'b0, 10'd0, 64'd0);
        lock0 = 1'b0;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
